// File: rtl/sh1_pkg.sv
// Shared SH-1 types and constants used by the instruction-fetch front end.
package sh1_pkg;
  typedef enum logic [1:0] {IDLE, REQ, DROP, HALT} fetch_state_e;

  localparam int          INST_W     = 16;
  localparam logic [15:0] NOP_OPCODE = 16'h0009;
endpackage

// File: rtl/sh1_halfword_fifo.sv
// Halfword opcode queue: up to two pushes and one pop per cycle.
// Entries shift toward slot 0 so the head opcode always comes straight from a flop.
module sh1_halfword_fifo
  import sh1_pkg::*;
#(
  parameter int QDEPTH = 4,
  parameter int CW     = $clog2(QDEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic [1:0]        push_n,
  input  logic [INST_W-1:0] push_d0,
  input  logic [INST_W-1:0] push_d1,
  input  logic              pop,
  output logic [INST_W-1:0] head,
  output logic [CW-1:0]     count,
  output logic [CW-1:0]     free
);
  logic [INST_W-1:0] slot_reg  [QDEPTH];
  logic [INST_W-1:0] slot_next [QDEPTH];
  logic [CW-1:0]     count_reg;
  logic [CW-1:0]     base;

  // New halves land just behind whatever survives this cycle's pop.
  assign base = count_reg - CW'(pop);

  genvar gi;
  for (gi = 0; gi < QDEPTH; gi++) begin : g_slot
    logic [INST_W-1:0] shifted;
    if (gi == QDEPTH - 1) begin : g_last
      assign shifted = pop ? '0 : slot_reg[gi];
    end else begin : g_mid
      assign shifted = pop ? slot_reg[gi+1] : slot_reg[gi];
    end
    assign slot_next[gi] = (push_n != 2'd0 && base == CW'(gi))            ? push_d0 :
                           (push_n == 2'd2 && base + CW'(1) == CW'(gi))   ? push_d1 :
                                                                            shifted;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
      for (int i = 0; i < QDEPTH; i++) slot_reg[i] <= '0;
    end else if (flush) begin
      count_reg <= '0;
      for (int i = 0; i < QDEPTH; i++) slot_reg[i] <= NOP_OPCODE;
    end else begin
      count_reg <= count_reg - CW'(pop) + CW'(push_n);
      for (int i = 0; i < QDEPTH; i++) slot_reg[i] <= slot_next[i];
    end
  end

  assign head  = slot_reg[0];
  assign count = count_reg;
  assign free  = CW'(QDEPTH) - count_reg;
endmodule

// File: rtl/sh1_fetch_unit.sv
// SH-1 fetch front end: one outstanding word read at a time, split into two
// big-endian opcodes and handed to the decoder over valid/ready with their PC.
module sh1_fetch_unit
  import sh1_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              mem_req,
  output logic [31:0]       mem_addr,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_err,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst_data,
  output logic [31:0]       inst_pc,
  input  logic              inst_ready,
  output logic              fetch_err
);
  localparam int CW = $clog2(QDEPTH) + 1;

  fetch_state_e      state_reg;
  logic [31:0]       fetch_pc_reg;
  logic [31:0]       mem_addr_reg;
  logic [31:0]       inst_pc_reg;
  logic              half_only_reg;
  logic              mem_req_reg;
  logic              fetch_err_reg;
  logic [CW-1:0]     q_count;
  logic [CW-1:0]     q_free;
  logic [CW-1:0]     want;
  logic              pop;
  logic              ack_ok;
  logic [1:0]        push_n;
  logic [INST_W-1:0] push_d0;
  logic [INST_W-1:0] push_d1;

  assign inst_valid = (q_count != '0);
  assign pop        = inst_valid && inst_ready && !redirect_valid;
  assign ack_ok     = (state_reg == REQ) && mem_ack && !mem_err && !redirect_valid;

  // A redirect into the odd half of a word only keeps the low opcode of that word.
  assign want    = half_only_reg ? CW'(1) : CW'(2);
  assign push_n  = !ack_ok ? 2'd0 : (half_only_reg ? 2'd1 : 2'd2);
  assign push_d0 = half_only_reg ? mem_rdata[15:0] : mem_rdata[31:16];
  assign push_d1 = mem_rdata[15:0];

  sh1_halfword_fifo #(.QDEPTH(QDEPTH), .CW(CW)) u_queue (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (redirect_valid),
    .push_n  (push_n),
    .push_d0 (push_d0),
    .push_d1 (push_d1),
    .pop     (pop),
    .head    (inst_data),
    .count   (q_count),
    .free    (q_free)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      fetch_pc_reg  <= RESET_PC & ~32'h3;
      mem_addr_reg  <= RESET_PC & ~32'h3;
      inst_pc_reg   <= RESET_PC & ~32'h1;
      half_only_reg <= RESET_PC[1];
      mem_req_reg   <= 1'b0;
      fetch_err_reg <= 1'b0;
    end else begin
      if (pop) inst_pc_reg <= inst_pc_reg + 32'd2;
      if (redirect_valid) begin
        inst_pc_reg   <= redirect_pc & ~32'h1;
        fetch_pc_reg  <= redirect_pc & ~32'h3;
        half_only_reg <= redirect_pc[1];
        fetch_err_reg <= 1'b0;
      end
      case (state_reg)
        IDLE: begin
          if (!redirect_valid && q_free >= want) begin
            state_reg    <= REQ;
            mem_req_reg  <= 1'b1;
            mem_addr_reg <= fetch_pc_reg;
          end
        end
        REQ: begin
          if (mem_ack) begin
            mem_req_reg <= 1'b0;
            if (redirect_valid) begin
              state_reg <= IDLE;
            end else if (mem_err) begin
              state_reg     <= HALT;
              fetch_err_reg <= 1'b1;
            end else begin
              state_reg     <= IDLE;
              fetch_pc_reg  <= fetch_pc_reg + 32'd4;
              half_only_reg <= 1'b0;
            end
          end else if (redirect_valid) begin
            state_reg <= DROP;
          end
        end
        // The abandoned access must still complete on the bus before a new one starts.
        DROP: begin
          if (mem_ack) begin
            mem_req_reg <= 1'b0;
            state_reg   <= IDLE;
          end
        end
        HALT: begin
          if (redirect_valid) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign mem_req   = mem_req_reg;
  assign mem_addr  = mem_addr_reg;
  assign inst_pc   = inst_pc_reg;
  assign fetch_err = fetch_err_reg;
endmodule
